// File: rtl/sdram_pkg.sv
// Shared types and constants for the SDRAM read/write burst scheduler.
// Frame defaults describe a 640x480 word frame with 512-word bursts.
package sdram_pkg;

  localparam int ADDR_W  = 24;
  localparam int BURST_W = 10;
  localparam int LVL_W   = 11;
  localparam int OFS_W   = 22;

  localparam logic [OFS_W-1:0]   DEF_ADDR_MIN   = 22'd0;
  localparam logic [OFS_W-1:0]   DEF_ADDR_MAX   = 22'd307200;
  localparam logic [BURST_W-1:0] DEF_WR_BURST   = 10'd512;
  localparam logic [BURST_W-1:0] DEF_RD_BURST   = 10'd512;
  localparam logic [LVL_W-1:0]   DEF_FIFO_DEPTH = 11'd1024;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_BUSY = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_BUSY = 3'd4
  } state_t;

  // One bit wider than the offset so the sum is compared before it can wrap.
  function automatic logic [OFS_W:0] ofs_advance(input logic [OFS_W-1:0] ofs,
                                                 input logic [BURST_W-1:0] len);
    return {1'b0, ofs} + {{(OFS_W + 1 - BURST_W){1'b0}}, len};
  endfunction

endpackage

// File: rtl/sdram_addr_gen.sv
// Linear burst offset and ping-pong buffer bit for one side (write or read).
// Loads during a burst are held pending and applied when that burst completes.
module sdram_addr_gen
  import sdram_pkg::*;
#(
  parameter logic [OFS_W-1:0]   ADDR_MIN = DEF_ADDR_MIN,
  parameter logic [OFS_W-1:0]   ADDR_MAX = DEF_ADDR_MAX,
  parameter logic [BURST_W-1:0] BURST    = DEF_WR_BURST,
  parameter logic               BUF_RST  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             busy_i,
  input  logic             done_i,
  input  logic             load_buf_i,
  input  logic             wrap_buf_i,
  output logic [OFS_W-1:0] ofs_o,
  output logic             buf_o
);

  logic [OFS_W-1:0] ofs_q, ofs_d;
  logic             buf_q, buf_d;
  logic             pend_q, pend_d;
  logic [OFS_W:0]   sum_s;

  // Next offset/buffer: completion (load wins over increment), else immediate or deferred load.
  always_comb begin
    sum_s  = ofs_advance(ofs_q, BURST);
    ofs_d  = ofs_q;
    buf_d  = buf_q;
    pend_d = pend_q;
    if (done_i) begin
      pend_d = 1'b0;
      if (load_i || pend_q) begin
        ofs_d = ADDR_MIN;
        buf_d = load_buf_i;
      end else if (sum_s >= {1'b0, ADDR_MAX}) begin
        ofs_d = ADDR_MIN;
        buf_d = wrap_buf_i;
      end else begin
        ofs_d = sum_s[OFS_W-1:0];
      end
    end else if (load_i) begin
      if (busy_i) begin
        pend_d = 1'b1;
      end else begin
        ofs_d  = ADDR_MIN;
        buf_d  = load_buf_i;
        pend_d = 1'b0;
      end
    end else begin
      pend_d = pend_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ofs_q  <= ADDR_MIN;
      buf_q  <= BUF_RST;
      pend_q <= 1'b0;
    end else begin
      ofs_q  <= ofs_d;
      buf_q  <= buf_d;
      pend_q <= pend_d;
    end
  end

  assign ofs_o = ofs_q;
  assign buf_o = buf_q;

endmodule

// File: rtl/sdram_rw_arbiter.sv
// Schedules fixed-length write/read bursts between the pixel FIFOs and the SDRAM
// controller; reads always use the frame buffer opposite the one being written.
module sdram_rw_arbiter
  import sdram_pkg::*;
#(
  parameter logic [OFS_W-1:0]   ADDR_MIN   = DEF_ADDR_MIN,
  parameter logic [OFS_W-1:0]   ADDR_MAX   = DEF_ADDR_MAX,
  parameter logic [BURST_W-1:0] WR_BURST   = DEF_WR_BURST,
  parameter logic [BURST_W-1:0] RD_BURST   = DEF_RD_BURST,
  parameter logic [LVL_W-1:0]   FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sdram_init_done,
  input  logic [LVL_W-1:0]   wfifo_level,
  input  logic [LVL_W-1:0]   rfifo_level,
  input  logic               rd_enable,
  input  logic               wr_load,
  input  logic               rd_load,
  output logic               sdram_wr_req,
  input  logic               sdram_wr_ack,
  output logic [ADDR_W-1:0]  sdram_wr_addr,
  output logic [BURST_W-1:0] sdram_wr_burst,
  output logic               sdram_rd_req,
  input  logic               sdram_rd_ack,
  output logic [ADDR_W-1:0]  sdram_rd_addr,
  output logic [BURST_W-1:0] sdram_rd_burst
);

  state_t           state_q, state_d;
  logic             wr_req_q, wr_req_d;
  logic             rd_req_q, rd_req_d;
  logic             wr_ack_dly_q, wr_ack_dly_d;
  logic             rd_ack_dly_q, rd_ack_dly_d;
  logic             wr_ready_s, rd_ready_s;
  logic             wr_done_s, rd_done_s;
  logic             wr_busy_s, rd_busy_s;
  logic [OFS_W-1:0] wr_ofs_s, rd_ofs_s;
  logic             wr_buf_s, rd_buf_s;

  assign wr_ready_s = (wfifo_level >= {1'b0, WR_BURST});
  assign rd_ready_s = rd_enable && (rfifo_level <= (FIFO_DEPTH - {1'b0, RD_BURST}));
  assign wr_busy_s  = (state_q == ST_WR_BUSY);
  assign rd_busy_s  = (state_q == ST_RD_BUSY);
  // A burst is complete on the falling edge of its ack.
  assign wr_done_s  = wr_busy_s && wr_ack_dly_q && !sdram_wr_ack;
  assign rd_done_s  = rd_busy_s && rd_ack_dly_q && !sdram_rd_ack;

  // Next-state and request logic; writes take priority over reads.
  always_comb begin
    state_d      = state_q;
    wr_req_d     = wr_req_q;
    rd_req_d     = rd_req_q;
    wr_ack_dly_d = sdram_wr_ack;
    rd_ack_dly_d = sdram_rd_ack;
    case (state_q)
      ST_IDLE: begin
        wr_req_d = 1'b0;
        rd_req_d = 1'b0;
        if (sdram_init_done && wr_ready_s) begin
          state_d  = ST_WR_REQ;
          wr_req_d = 1'b1;
        end else if (sdram_init_done && rd_ready_s) begin
          state_d  = ST_RD_REQ;
          rd_req_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WR_REQ: begin
        if (sdram_wr_ack) begin
          state_d  = ST_WR_BUSY;
          wr_req_d = 1'b0;
        end else begin
          wr_req_d = 1'b1;
        end
      end
      ST_WR_BUSY: begin
        wr_req_d = 1'b0;
        if (wr_done_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WR_BUSY;
        end
      end
      ST_RD_REQ: begin
        if (sdram_rd_ack) begin
          state_d  = ST_RD_BUSY;
          rd_req_d = 1'b0;
        end else begin
          rd_req_d = 1'b1;
        end
      end
      ST_RD_BUSY: begin
        rd_req_d = 1'b0;
        if (rd_done_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RD_BUSY;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        wr_req_d = 1'b0;
        rd_req_d = 1'b0;
      end
    endcase
  end

  // FSM, registered requests and ack edge detectors.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      wr_req_q     <= 1'b0;
      rd_req_q     <= 1'b0;
      wr_ack_dly_q <= 1'b0;
      rd_ack_dly_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_req_q     <= wr_req_d;
      rd_req_q     <= rd_req_d;
      wr_ack_dly_q <= wr_ack_dly_d;
      rd_ack_dly_q <= rd_ack_dly_d;
    end
  end

  sdram_addr_gen #(
    .ADDR_MIN (ADDR_MIN),
    .ADDR_MAX (ADDR_MAX),
    .BURST    (WR_BURST),
    .BUF_RST  (1'b0)
  ) u_wr_addr (
    .clk        (clk),
    .rst        (rst),
    .load_i     (wr_load),
    .busy_i     (wr_busy_s),
    .done_i     (wr_done_s),
    .load_buf_i (wr_buf_s),
    .wrap_buf_i (~wr_buf_s),
    .ofs_o      (wr_ofs_s),
    .buf_o      (wr_buf_s)
  );

  // Reads restart on the last completed frame: the buffer not being written.
  sdram_addr_gen #(
    .ADDR_MIN (ADDR_MIN),
    .ADDR_MAX (ADDR_MAX),
    .BURST    (RD_BURST),
    .BUF_RST  (1'b1)
  ) u_rd_addr (
    .clk        (clk),
    .rst        (rst),
    .load_i     (rd_load),
    .busy_i     (rd_busy_s),
    .done_i     (rd_done_s),
    .load_buf_i (~wr_buf_s),
    .wrap_buf_i (~wr_buf_s),
    .ofs_o      (rd_ofs_s),
    .buf_o      (rd_buf_s)
  );

  assign sdram_wr_req   = wr_req_q;
  assign sdram_rd_req   = rd_req_q;
  assign sdram_wr_addr  = {1'b0, wr_buf_s, wr_ofs_s};
  assign sdram_rd_addr  = {1'b0, rd_buf_s, rd_ofs_s};
  assign sdram_wr_burst = WR_BURST;
  assign sdram_rd_burst = RD_BURST;

endmodule

// File: tb/tb_sdram_rw_arbiter.sv
// Directed bench for sdram_rw_arbiter with a frame-address model checked every cycle.
module tb_sdram_rw_arbiter;

  localparam int MAXO = 307200;
  localparam int BL   = 512;

  logic        clk = 1'b0;
  logic        rst, init_done, rd_en, wr_load, rd_load, wr_ack, rd_ack;
  logic [10:0] wfifo, rfifo;
  logic        wr_req, rd_req;
  logic [23:0] wr_addr, rd_addr;
  logic [9:0]  wr_burst, rd_burst;

  int checks = 0;
  int errors = 0;

  int m_wr_ofs, m_rd_ofs;
  bit m_wr_buf, m_rd_buf, m_wr_pend, m_rd_pend;
  bit model_on = 1'b0;

  always #5 clk = ~clk;

  sdram_rw_arbiter dut (
    .clk             (clk),
    .rst             (rst),
    .sdram_init_done (init_done),
    .wfifo_level     (wfifo),
    .rfifo_level     (rfifo),
    .rd_enable       (rd_en),
    .wr_load         (wr_load),
    .rd_load         (rd_load),
    .sdram_wr_req    (wr_req),
    .sdram_wr_ack    (wr_ack),
    .sdram_wr_addr   (wr_addr),
    .sdram_wr_burst  (wr_burst),
    .sdram_rd_req    (rd_req),
    .sdram_rd_ack    (rd_ack),
    .sdram_rd_addr   (rd_addr),
    .sdram_rd_burst  (rd_burst)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] exp_addr(input bit b, input int ofs);
    logic [23:0] a;
    a = 24'(ofs);
    if (b) a = a + 24'h400000;
    return a;
  endfunction

  task automatic model_reset();
    m_wr_ofs = 0; m_wr_buf = 1'b0; m_wr_pend = 1'b0;
    m_rd_ofs = 0; m_rd_buf = 1'b1; m_rd_pend = 1'b0;
  endtask

  // Frame bookkeeping when a burst finishes: advance, wrap with buffer swap, or restart.
  task automatic model_done(input bit is_wr, input bit load_now);
    if (is_wr) begin
      if (load_now || m_wr_pend) begin
        m_wr_ofs = 0; m_wr_pend = 1'b0;
      end else begin
        m_wr_ofs += BL;
        if (m_wr_ofs >= MAXO) begin m_wr_ofs = 0; m_wr_buf = !m_wr_buf; end
      end
    end else begin
      if (load_now || m_rd_pend) begin
        m_rd_ofs = 0; m_rd_buf = !m_wr_buf; m_rd_pend = 1'b0;
      end else begin
        m_rd_ofs += BL;
        if (m_rd_ofs >= MAXO) begin m_rd_ofs = 0; m_rd_buf = !m_wr_buf; end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_load(input bit is_wr, input logic v);
    if (is_wr) wr_load = v;
    else rd_load = v;
  endtask

  task automatic wait_req(input bit is_wr, input int max);
    int n = 0;
    while (((is_wr ? wr_req : rd_req) !== 1'b1) && n < max) begin
      tick();
      n++;
    end
    chk(is_wr ? "wr_req_wait" : "rd_req_wait", is_wr ? wr_req : rd_req, 32'd1);
  endtask

  // One full handshake; load_at = k pulses the load k cycles into the burst
  // (k == ack_len coincides with the ack falling edge), -1 for none.
  task automatic run_burst(input bit is_wr, input int ack_len, input int load_at);
    wait_req(is_wr, 8);
    if (is_wr) wr_ack = 1'b1; else rd_ack = 1'b1;
    tick();
    chk("req_drop_on_ack", is_wr ? wr_req : rd_req, 32'd0);
    for (int k = 1; k < ack_len; k++) begin
      if (load_at == k) begin
        set_load(is_wr, 1'b1);
        if (is_wr) m_wr_pend = 1'b1; else m_rd_pend = 1'b1;
      end
      tick();
      set_load(is_wr, 1'b0);
    end
    wr_ack = 1'b0;
    rd_ack = 1'b0;
    if (load_at == ack_len) set_load(is_wr, 1'b1);
    tick();
    set_load(is_wr, 1'b0);
    model_done(is_wr, load_at == ack_len);
  endtask

  // Every cycle: addresses must match the frame model, bursts are fixed, one request at a time.
  always @(negedge clk) begin
    if (model_on) begin
      chk("wr_addr", wr_addr, exp_addr(m_wr_buf, m_wr_ofs));
      chk("rd_addr", rd_addr, exp_addr(m_rd_buf, m_rd_ofs));
      chk("wr_burst", wr_burst, 32'd512);
      chk("rd_burst", rd_burst, 32'd512);
      chk("req_exclusive", wr_req & rd_req, 32'd0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int seen;
    rst = 1'b1; init_done = 1'b0; rd_en = 1'b0; wr_load = 1'b0; rd_load = 1'b0;
    wr_ack = 1'b0; rd_ack = 1'b0; wfifo = 11'd0; rfifo = 11'd0;
    tick();
    model_reset();
    model_on = 1'b1;
    tick(); tick();
    chk("reset_wr_req", wr_req, 32'd0);
    chk("reset_rd_req", rd_req, 32'd0);
    chk("reset_wr_addr", wr_addr, 32'h000000);
    chk("reset_rd_addr", rd_addr, 32'h400000);
    rst = 1'b0;

    // Init gating
    wfifo = 11'd600;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (wr_req || rd_req) seen++;
    end
    chk("init_gate_no_req", seen, 32'd0);
    init_done = 1'b1;
    wait_req(1'b1, 2);
    chk("first_wr_addr", wr_addr, 32'h000000);

    // Long burst, then the mandatory idle cycle before the next request
    run_burst(1'b1, 512, -1);
    chk("idle_gap", wr_req, 32'd0);
    tick();
    chk("req_after_gap", wr_req, 32'd1);
    chk("second_wr_addr", wr_addr, 32'h000200);
    run_burst(1'b1, 1, -1);

    // Deferred and coincident loads
    wait_req(1'b1, 4);
    chk("third_wr_addr", wr_addr, 32'h000400);
    run_burst(1'b1, 4, 2);
    wait_req(1'b1, 4);
    chk("deferred_load_addr", wr_addr, 32'h000000);
    run_burst(1'b1, 3, 3);
    wait_req(1'b1, 4);
    chk("coincident_load_addr", wr_addr, 32'h000000);
    run_burst(1'b1, 1, -1);

    // Load while a request is pending takes effect before the ack
    wait_req(1'b1, 4);
    chk("pre_load_addr", wr_addr, 32'h000200);
    wr_load = 1'b1;
    tick();
    wr_load = 1'b0;
    m_wr_ofs = 0;
    chk("load_in_req_addr", wr_addr, 32'h000000);
    chk("load_in_req_still_req", wr_req, 32'd1);
    run_burst(1'b1, 1, -1);
    wfifo = 11'd0;

    // Spurious acks in IDLE are ignored
    wr_ack = 1'b1; rd_ack = 1'b1;
    tick(); tick();
    wr_ack = 1'b0; rd_ack = 1'b0;
    tick(); tick();
    chk("spurious_wr_req", wr_req, 32'd0);
    chk("spurious_rd_req", rd_req, 32'd0);

    // Priority: write first, then read from buffer 1
    wfifo = 11'd512; rd_en = 1'b1; rfifo = 11'd0;
    tick();
    chk("prio_wr_req", wr_req, 32'd1);
    chk("prio_rd_req", rd_req, 32'd0);
    wfifo = 11'd0;
    run_burst(1'b1, 2, -1);
    wait_req(1'b0, 4);
    chk("first_rd_addr", rd_addr, 32'h400000);
    run_burst(1'b0, 2, -1);
    rd_en = 1'b0;

    // Level thresholds: 511 / 513 hold off, 512 / 512 request
    rd_en = 1'b1; rfifo = 11'd513; wfifo = 11'd511;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (wr_req || rd_req) seen++;
    end
    chk("threshold_no_req", seen, 32'd0);
    rfifo = 11'd512;
    wait_req(1'b0, 3);
    run_burst(1'b0, 1, -1);
    rd_en = 1'b0; wfifo = 11'd512;
    wait_req(1'b1, 3);
    chk("thresh_wr_addr", wr_addr, 32'h000400);
    wfifo = 11'd0;
    run_burst(1'b1, 1, -1);

    // Full write frame: 600 bursts wrap into buffer 1
    wr_load = 1'b1;
    tick();
    wr_load = 1'b0;
    m_wr_ofs = 0;
    wfifo = 11'd600;
    for (int i = 0; i < 600; i++) run_burst(1'b1, 1, -1);
    wfifo = 11'd0;
    chk("wr_wrap_addr", wr_addr, 32'h400000);

    // Read frame wraps onto the buffer opposite the writer
    rd_en = 1'b1; rfifo = 11'd0;
    for (int i = 0; i < 700 && m_rd_buf != 1'b0; i++) run_burst(1'b0, 1, -1);
    rd_en = 1'b0;
    chk("rd_wrap_addr", rd_addr, 32'h000000);

    // Read loads: immediate in IDLE, deferred mid-burst
    rd_en = 1'b1;
    run_burst(1'b0, 1, -1);
    rd_en = 1'b0;
    rd_load = 1'b1;
    tick();
    rd_load = 1'b0;
    m_rd_ofs = 0; m_rd_buf = !m_wr_buf;
    chk("rd_load_idle_addr", rd_addr, 32'h000000);
    rd_en = 1'b1;
    run_burst(1'b0, 1, -1);
    run_burst(1'b0, 3, 1);
    rd_en = 1'b0;
    chk("rd_load_deferred_addr", rd_addr, 32'h000000);

    // Reset in the middle of a read burst
    rd_en = 1'b1;
    wait_req(1'b0, 4);
    rd_ack = 1'b1;
    tick(); tick();
    rst = 1'b1; wfifo = 11'd600;
    tick();
    model_reset();
    chk("rst_wr_req", wr_req, 32'd0);
    chk("rst_rd_req", rd_req, 32'd0);
    chk("rst_rd_addr", rd_addr, 32'h400000);
    chk("rst_wr_addr", wr_addr, 32'h000000);
    rd_ack = 1'b0;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (wr_req || rd_req) seen++;
    end
    chk("rst_hold_no_req", seen, 32'd0);
    rst = 1'b0; rd_en = 1'b0;
    wait_req(1'b1, 4);
    chk("post_rst_wr_addr", wr_addr, 32'h000000);
    run_burst(1'b1, 1, -1);
    wfifo = 11'd0;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdram_rw_arbiter.md
Name: sdram_rw_arbiter

Overview:
- Single-clock scheduler between the write/read pixel FIFOs and the SDRAM controller's write and read ports.
- Watches the FIFO fill levels and issues fixed-length burst requests.
- Generates linear burst addresses inside a frame window, with wrap-around.
- Manages ping-pong frame buffers so reads never touch the frame currently being written.

Parameters:
- ADDR_MIN, 22'd0, first word offset of the frame window.
- ADDR_MAX, 22'd307200, one past the last word offset (640x480).
- WR_BURST, 10'd512, burst length for writes.
- RD_BURST, 10'd512, burst length for reads.
- FIFO_DEPTH, 11'd1024, depth of the read FIFO.

Ports:
- clk  in  1  controller clock (same clock as the SDRAM controller)
- rst  in  1  synchronous, active-high reset
- sdram_init_done  in  1  SDRAM initialization complete
- wfifo_level  in  11  words available in the write FIFO
- rfifo_level  in  11  words stored in the read FIFO
- rd_enable  in  1  display wants data; reads are inhibited when low
- wr_load  in  1  one-cycle pulse: restart write frame at ADDR_MIN
- rd_load  in  1  one-cycle pulse: restart read frame at ADDR_MIN
- sdram_wr_req  out  1  write burst request
- sdram_wr_ack  in  1  high for the duration of the write burst
- sdram_wr_addr  out  24  {1'b0, wr_buf, wr_ofs[21:0]}
- sdram_wr_burst  out  10  always WR_BURST
- sdram_rd_req  out  1  read burst request
- sdram_rd_ack  in  1  high for the duration of the read burst
- sdram_rd_addr  out  24  {1'b0, rd_buf, rd_ofs[21:0]}
- sdram_rd_burst  out  10  always RD_BURST

Behaviour:
- Reset values: both req = 0, wr_ofs = rd_ofs = ADDR_MIN, wr_buf = 0, rd_buf = 1, state = IDLE, pending-load flags = 0.
- Reset is synchronous: rst taken mid-burst drops both req next edge and returns to IDLE; the controller's own burst is not aborted by this block.
- FSM states: IDLE, WR_REQ, WR_BUSY, RD_REQ, RD_BUSY.
- IDLE: requests are evaluated only while sdram_init_done = 1. Priority order:
  - wfifo_level >= WR_BURST -> WR_REQ.
  - else rd_enable && (rfifo_level <= FIFO_DEPTH - RD_BURST) -> RD_REQ.
  - else stay in IDLE.
- WR_REQ: sdram_wr_req = 1 (registered; asserted the cycle after the IDLE decision). Stays here until sdram_wr_ack = 1, then req drops the same edge and the FSM moves to WR_BUSY.
- WR_BUSY: waits for the falling edge of sdram_wr_ack (registered ack_d = 1, ack = 0). That edge means the burst is complete:
  - wr_ofs += WR_BURST.
  - If the new value >= ADDR_MAX, wr_ofs = ADDR_MIN and wr_buf toggles.
  - FSM returns to IDLE.
- RD_REQ / RD_BUSY: identical handshake using the rd signals and RD_BURST.
  - Read wrap sets rd_ofs = ADDR_MIN and rd_buf = ~wr_buf, so reads take the last completed frame.
- Request to request: a minimum of 1 IDLE cycle between bursts.
- Offset arithmetic is 23-bit internally so that the sum cannot overflow before the compare.
- Address outputs are registered and stable while req or ack is high. They change only on burst completion or load.
- wr_load:
  - In IDLE or WR_REQ: wr_ofs = ADDR_MIN next edge and wr_buf is unchanged (in WR_REQ the address updates before ack).
  - In WR_BUSY: latched into pend_wr_load and applied at burst completion, overriding the increment.
  - If wr_load and burst completion occur in the same cycle, the load wins.
- rd_load: handled the same way on the read side; on application, rd_buf = ~wr_buf.
- Ack arriving while req is not asserted (spurious) is ignored in IDLE.
- sdram_init_done falling mid-burst does not interrupt the burst; no new request is issued afterwards.

Decomposition:
- Shared package sdram_pkg: FSM state enum, address/burst widths (ADDR_W = 24, BURST_W = 10, LVL_W = 11), default frame constants.
- One natural sub-module, sdram_addr_gen, instantiated twice (write side, read side). It holds:
  - offset register
  - buffer bit
  - pending-load flag
  - increment/wrap/load logic
- The top level holds the FSM and the ack edge detectors.

Test Plan:
- Init gating: init_done = 0, wfifo_level = 600 for 100 cycles -> no req. Raise init_done -> sdram_wr_req = 1 within 2 cycles, sdram_wr_addr = 24'h000000.
- Write burst: ack held high 512 cycles then low -> req drops on the first ack cycle. Next write request has addr 24'h000200 (512).
- Priority: wfifo_level = 512, rd_enable = 1, rfifo_level = 0 simultaneously -> write issued first. After it completes with wfifo_level = 0 -> read issued with rd_addr = 24'h400000 (rd_buf = 1).
- Wrap/ping-pong: 600 write bursts with ADDR_MAX = 307200 -> the 600th completion sets wr_ofs = 0 and wr_buf = 1, so the next wr_addr = 24'h400000. The next read wrap yields rd_buf = 0.
- Deferred load: wr_load pulsed mid-WR_BUSY at wr_ofs = 1024 -> after ack falls, the next wr_addr = 24'h000000 (not 1536). With load and completion coincident, the result is also 0.
- Reset mid-burst: rst during RD_BUSY -> next edge both req = 0, rd_ofs = 0, rd_buf = 1; no request while rst = 1.
